// File: rtl/mca_histogram_ctrl.sv
// Multichannel-analyser histogram controller.
// Sequences clear / acquire / done phases for a single-port histogram RAM.
// Each accepted pulse is binned and read-modify-write incremented.
// Host reads share the same RAM port while the controller is quiescent.
module mca_histogram_ctrl #(
  parameter int BIN_BITS = 10,
  parameter int COUNT_W  = 32
) (
  input  logic                CLOCK_65,
  input  logic                rst_n,
  input  logic                pulse_indicator,
  input  logic [13:0]         pulse_height,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic [COUNT_W-1:0]  preset_counts,
  input  logic                rd_req,
  input  logic [BIN_BITS-1:0] rd_addr,
  output logic [COUNT_W-1:0]  rd_data,
  output logic                rd_valid,
  output logic [BIN_BITS-1:0] ram_addr,
  output logic [COUNT_W-1:0]  ram_wdata,
  output logic                ram_we,
  input  logic [COUNT_W-1:0]  ram_rdata,
  output logic [1:0]          state,
  output logic [COUNT_W-1:0]  total_count,
  output logic [COUNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ACQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_RD   = 2'd1,
    E_WR   = 2'd2
  } eng_t;

  localparam logic [BIN_BITS-1:0] LAST_BIN = {BIN_BITS{1'b1}};

  // Saturating increment shared by the bin update and both counters.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    sat_inc = (&v) ? v : v + COUNT_W'(1);
  endfunction

  state_t               st_q, st_nxt;
  eng_t                 eng_q, eng_nxt;
  logic [BIN_BITS-1:0]  clr_addr_q;
  logic                 clr_en_q;
  logic [BIN_BITS-1:0]  bin_q;
  logic                 ending_q;
  logic                 rd_ph1_q;
  logic [BIN_BITS-1:0]  rd_addr_q;
  logic [COUNT_W-1:0]   rd_data_q;
  logic                 pend_clr_q;
  logic                 pend_start_q;

  logic                 accept;
  logic                 drop_hit;
  logic                 acq_open;
  logic                 preset_hit;
  logic                 finishing;
  logic                 do_clear;
  logic                 do_start;
  logic                 rd_accept;
  logic                 latch_cmd;
  logic [COUNT_W-1:0]   total_inc;

  logic [BIN_BITS-1:0]  pulse_bin;
  logic                 unused_low_bits;

  assign pulse_bin       = pulse_height[13 -: BIN_BITS];
  assign unused_low_bits = ^pulse_height[13-BIN_BITS:0];
  assign total_inc       = sat_inc(total_count);
  assign state           = st_q;
  // rd_data shows the fresh RAM word during the rd_valid cycle, then holds it.
  assign rd_data         = rd_valid ? ram_rdata : rd_data_q;

  // Controller and increment-engine state registers.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_CLEAR;
      eng_q <= E_IDLE;
    end else begin
      st_q  <= st_nxt;
      eng_q <= eng_nxt;
    end
  end

  // Next-state decode: phase sequencing, pulse acceptance and command arbitration.
  always_comb begin
    st_nxt     = st_q;
    eng_nxt    = eng_q;
    accept     = 1'b0;
    drop_hit   = 1'b0;
    acq_open   = 1'b0;
    preset_hit = 1'b0;
    finishing  = 1'b0;
    do_clear   = 1'b0;
    do_start   = 1'b0;
    rd_accept  = 1'b0;
    latch_cmd  = 1'b0;
    case (st_q)
      S_CLEAR: begin
        if (clr_en_q && (clr_addr_q == LAST_BIN)) st_nxt = S_IDLE;
      end
      S_IDLE, S_DONE: begin
        // Commands wait out a read whose RAM address phase is in progress.
        if (rd_ph1_q) begin
          latch_cmd = 1'b1;
        end else if (clear || pend_clr_q) begin
          do_clear = 1'b1;
          st_nxt   = S_CLEAR;
        end else if (start || pend_start_q) begin
          do_start = 1'b1;
          st_nxt   = S_ACQ;
        end else if (rd_req && !rd_valid) begin
          rd_accept = 1'b1;
        end
      end
      S_ACQ: begin
        acq_open = !ending_q && !stop;
        case (eng_q)
          E_IDLE: begin
            if (acq_open && pulse_indicator) begin
              accept  = 1'b1;
              eng_nxt = E_RD;
            end
          end
          E_RD: begin
            eng_nxt  = E_WR;
            drop_hit = acq_open && pulse_indicator;
          end
          E_WR: begin
            eng_nxt  = E_IDLE;
            drop_hit = acq_open && pulse_indicator;
          end
          default: eng_nxt = E_IDLE;
        endcase
        preset_hit = accept && (preset_counts != '0) && (total_inc == preset_counts);
        finishing  = ending_q || stop || preset_hit;
        if (finishing && (eng_nxt == E_IDLE)) st_nxt = S_DONE;
      end
      default: st_nxt = S_CLEAR;
    endcase
  end

  // RAM port mux: exactly one owner per cycle, decided by controller phase.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (st_q == S_CLEAR) begin
      ram_we   = clr_en_q;
      ram_addr = clr_addr_q;
    end else if ((st_q == S_ACQ) && (eng_q != E_IDLE)) begin
      ram_addr = bin_q;
      if (eng_q == E_WR) begin
        ram_we    = 1'b1;
        ram_wdata = sat_inc(ram_rdata);
      end
    end else if (rd_ph1_q) begin
      ram_addr = rd_addr_q;
    end
  end

  // Clear sweep address; the first cycle out of reset arms the sweep.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
      clr_en_q   <= 1'b0;
    end else if (do_clear) begin
      clr_addr_q <= '0;
      clr_en_q   <= 1'b1;
    end else if (st_q == S_CLEAR) begin
      if (!clr_en_q) begin
        clr_en_q <= 1'b1;
      end else if (clr_addr_q == LAST_BIN) begin
        clr_addr_q <= '0;
        clr_en_q   <= 1'b0;
      end else begin
        clr_addr_q <= clr_addr_q + BIN_BITS'(1);
      end
    end
  end

  // Acquisition bookkeeping: latched bin, end-of-run flag, saturating counters.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      ending_q    <= 1'b0;
      total_count <= '0;
      drop_count  <= '0;
    end else begin
      if (accept) bin_q <= pulse_bin;
      ending_q <= (st_q == S_ACQ) && finishing && (st_nxt == S_ACQ);
      if (do_start) begin
        total_count <= '0;
        drop_count  <= '0;
      end else begin
        if (accept)   total_count <= total_inc;
        if (drop_hit) drop_count  <= sat_inc(drop_count);
      end
    end
  end

  // Host readout pipeline and deferred commands raised during a read.
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ph1_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_valid     <= 1'b0;
      rd_data_q    <= '0;
      pend_clr_q   <= 1'b0;
      pend_start_q <= 1'b0;
    end else begin
      rd_ph1_q <= rd_accept;
      rd_valid <= rd_ph1_q;
      if (rd_accept) rd_addr_q <= rd_addr;
      if (rd_valid)  rd_data_q <= ram_rdata;
      if (latch_cmd) begin
        pend_clr_q   <= pend_clr_q   | clear;
        pend_start_q <= pend_start_q | start;
      end else if (do_clear || do_start) begin
        pend_clr_q   <= 1'b0;
        pend_start_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mca_histogram_ctrl.sv
// Bench for mca_histogram_ctrl: behavioural RAM, histogram model and
// pulse-acceptance rules computed from cycle indices.
module tb_mca_histogram_ctrl;

  localparam int BIN_BITS = 10;
  localparam int COUNT_W  = 32;
  localparam int NB       = 1 << BIN_BITS;
  localparam int SHIFT    = 14 - BIN_BITS;

  logic                CLOCK_65 = 1'b0;
  logic                rst_n;
  logic                pulse_indicator;
  logic [13:0]         pulse_height;
  logic                start, stop, clear;
  logic [COUNT_W-1:0]  preset_counts;
  logic                rd_req;
  logic [BIN_BITS-1:0] rd_addr;
  logic [COUNT_W-1:0]  rd_data;
  logic                rd_valid;
  logic [BIN_BITS-1:0] ram_addr;
  logic [COUNT_W-1:0]  ram_wdata;
  logic                ram_we;
  logic [COUNT_W-1:0]  ram_rdata;
  logic [1:0]          state;
  logic [COUNT_W-1:0]  total_count;
  logic [COUNT_W-1:0]  drop_count;

  always #5 CLOCK_65 = ~CLOCK_65;

  mca_histogram_ctrl #(.BIN_BITS(BIN_BITS), .COUNT_W(COUNT_W)) dut (
    .CLOCK_65(CLOCK_65), .rst_n(rst_n),
    .pulse_indicator(pulse_indicator), .pulse_height(pulse_height),
    .start(start), .stop(stop), .clear(clear), .preset_counts(preset_counts),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .state(state),
    .total_count(total_count), .drop_count(drop_count)
  );

  // Single-port RAM, one-cycle read latency, with a bench preload port.
  logic [COUNT_W-1:0]  mem [NB];
  logic                pl_en;
  logic [BIN_BITS-1:0] pl_addr;
  logic [COUNT_W-1:0]  pl_val;

  always @(posedge CLOCK_65) begin
    if (pl_en)       mem[pl_addr]  <= pl_val;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Port-ownership monitors.
  int clr_writes = 0;
  int bad_we     = 0;
  int bad_rdv    = 0;
  always @(negedge CLOCK_65) begin
    if (rst_n === 1'b1) begin
      if (ram_we && state == 2'd0) clr_writes++;
      if (ram_we && (state == 2'd1 || state == 2'd3)) bad_we++;
      if (rd_valid && (state == 2'd0 || state == 2'd2)) bad_rdv++;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [COUNT_W-1:0] hist [NB];
  bit                 ev_p [256];
  logic [13:0]        ev_h [256];
  int                 stop_at;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_65);
    cyc++;
  endtask

  task automatic clr_ev();
    for (int i = 0; i < 256; i++) begin
      ev_p[i] = 1'b0;
      ev_h[i] = '0;
    end
    stop_at = -1;
  endtask

  task automatic read_bin(input int a, input bit detail);
    rd_req  = 1'b1;
    rd_addr = BIN_BITS'(a);
    tick();
    rd_req = 1'b0;
    if (detail) begin
      check_eq("rd_addr_phase", ram_addr, a);
      check_eq("rd_valid_t1", rd_valid, 0);
    end
    tick();
    if (detail) check_eq("rd_valid_t2", rd_valid, 1);
    check_eq("rd_data", rd_data, hist[a]);
    tick();
    if (detail) begin
      check_eq("rd_valid_t3", rd_valid, 0);
      check_eq("rd_data_hold", rd_data, hist[a]);
    end
  endtask

  task automatic count_nonzero_mem(output int n);
    n = 0;
    for (int i = 0; i < NB; i++) if (mem[i] != '0) n++;
  endtask

  // Run one acquisition from IDLE/DONE using ev_p/ev_h/stop_at.
  task automatic run_acq(input logic [COUNT_W-1:0] preset, input int ncyc, input bit noise);
    bit                 ended;
    int                 last_acc, done_exp, done_seen, b;
    logic [COUNT_W-1:0] tot, drp;
    preset_counts = preset;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("acq_entry_state", state, 2);
    check_eq("acq_entry_total", total_count, 0);
    check_eq("acq_entry_drop", drop_count, 0);
    ended = 1'b0; last_acc = -100; done_exp = -1; done_seen = -1;
    tot = '0; drp = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (state == 2'd3 && done_seen < 0) done_seen = c;
      pulse_indicator = ev_p[c];
      pulse_height    = ev_h[c];
      stop            = (c == stop_at);
      if (noise && !ended) begin
        rd_req  = ($urandom_range(0, 5) == 0);
        rd_addr = BIN_BITS'($urandom);
        clear   = ($urandom_range(0, 9) == 0);
        start   = ($urandom_range(0, 9) == 0);
      end else begin
        rd_req = 1'b0; clear = 1'b0; start = 1'b0;
      end
      if (!ended) begin
        if (c == stop_at) begin
          ended    = 1'b1;
          done_exp = (c + 1 > last_acc + 3) ? c + 1 : last_acc + 3;
        end else if (ev_p[c]) begin
          if (c >= last_acc + 3) begin
            last_acc = c;
            tot++;
            b = int'(ev_h[c]) >> SHIFT;
            if (hist[b] != '1) hist[b] = hist[b] + 1;
            if (preset != '0 && tot == preset) begin
              ended    = 1'b1;
              done_exp = c + 3;
            end
          end else begin
            drp++;
          end
        end
      end
      tick();
    end
    pulse_indicator = 1'b0; stop = 1'b0; rd_req = 1'b0; clear = 1'b0; start = 1'b0;
    for (int k = 0; k < 8 && done_seen < 0; k++) begin
      if (state == 2'd3) done_seen = ncyc + k;
      else tick();
    end
    check_eq("done_cycle", done_seen, done_exp);
    check_eq("done_state", state, 3);
    check_eq("total_count", total_count, tot);
    check_eq("drop_count", drop_count, drp);
  endtask

  task automatic expect_sweep(input int w0);
    int nz;
    nz = 0;
    for (int i = 0; i < NB - 1; i++) begin
      tick();
      if (state != 2'd0) nz++;
    end
    check_eq("clear_state_held", nz, 0);
    tick();
    check_eq("clear_to_idle", state, 1);
    check_eq("clear_write_count", clr_writes - w0, NB);
    count_nonzero_mem(nz);
    check_eq("clear_mem_zero", nz, 0);
    for (int i = 0; i < NB; i++) hist[i] = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w0, b, n;
    rst_n = 1'b0;
    pulse_indicator = 1'b0; pulse_height = '0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; preset_counts = '0;
    rd_req = 1'b0; rd_addr = '0;
    pl_en = 1'b1; pl_addr = '0; pl_val = '0;
    clr_ev();

    // Fill RAM with nonzero garbage while reset is held.
    for (int i = 0; i < NB; i++) begin
      pl_addr = BIN_BITS'(i);
      pl_val  = $urandom | 32'h1;
      tick();
    end
    pl_en = 1'b0;
    tick();
    check_eq("rst_state", state, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_ram_wdata", ram_wdata, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_total", total_count, 0);
    check_eq("rst_drop", drop_count, 0);

    // Power-up sweep: state 0 for 1024 sampled cycles, then IDLE.
    w0 = clr_writes;
    rst_n = 1'b1;
    tick();
    check_eq("sweep_first_addr", ram_addr, 0);
    check_eq("sweep_first_we", ram_we, 1);
    expect_sweep(w0);
    read_bin($urandom_range(0, NB - 1), 1'b1);

    // Five full-scale pulses spaced 4 cycles, then stop.
    clr_ev();
    for (int i = 0; i < 5; i++) begin
      ev_p[1 + 4 * i] = 1'b1;
      ev_h[1 + 4 * i] = 14'h3FFF;
    end
    stop_at = 22;
    run_acq('0, 26, 1'b0);
    read_bin(NB - 1, 1'b1);

    // Back-to-back pulses: second one is dropped.
    clr_ev();
    ev_p[1] = 1'b1; ev_h[1] = 14'h0010;
    ev_p[2] = 1'b1; ev_h[2] = 14'h0020;
    stop_at = 6;
    run_acq('0, 10, 1'b0);
    read_bin(14'h0010 >> SHIFT, 1'b0);
    read_bin(14'h0020 >> SHIFT, 1'b0);

    // Preset of 3: fourth pulse arrives after the run has ended.
    clr_ev();
    for (int i = 0; i < 4; i++) begin
      ev_p[1 + 4 * i] = 1'b1;
      ev_h[1 + 4 * i] = 14'h0100;
    end
    run_acq(32'd3, 20, 1'b0);
    read_bin(14'h0100 >> SHIFT, 1'b0);

    // Saturation: a full bin stays full.
    b = $urandom_range(100, 900);
    pl_en = 1'b1; pl_addr = BIN_BITS'(b); pl_val = '1;
    tick();
    pl_en = 1'b0;
    hist[b] = '1;
    clr_ev();
    ev_p[2] = 1'b1; ev_h[2] = 14'((b << SHIFT) | $urandom_range(0, 15));
    stop_at = 7;
    run_acq('0, 10, 1'b0);
    read_bin(b, 1'b1);

    // Start raised during an outstanding read takes effect after rd_valid.
    b = $urandom_range(0, NB - 1);
    rd_req = 1'b1; rd_addr = BIN_BITS'(b);
    tick();
    rd_req = 1'b0; start = 1'b1;
    check_eq("defer_t1_state", state, 3);
    tick();
    start = 1'b0;
    check_eq("defer_t2_valid", rd_valid, 1);
    check_eq("defer_t2_data", rd_data, hist[b]);
    check_eq("defer_t2_state", state, 3);
    tick();
    check_eq("defer_t3_state", state, 2);
    check_eq("defer_total", total_count, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("defer_stop_done", state, 3);

    // Randomized runs with command/read noise during ACQ.
    for (int r = 0; r < 4; r++) begin
      clr_ev();
      for (int c = 0; c < 80; c++) begin
        ev_p[c] = ($urandom_range(0, 2) == 0);
        ev_h[c] = 14'(($urandom_range(0, 15) << SHIFT) | $urandom_range(0, 15));
      end
      stop_at = $urandom_range(60, 75);
      run_acq((r % 2) ? 32'($urandom_range(2, 12)) : '0, 80, 1'b1);
    end
    n = 0;
    for (int i = 0; i < NB; i++) begin
      read_bin(i, 1'b0);
    end

    // start+clear together in DONE: clear wins.
    w0 = clr_writes;
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check_eq("startclr_state", state, 0);
    expect_sweep(w0);
    read_bin($urandom_range(0, NB - 1), 1'b1);

    check_eq("we_outside_owner", bad_we, 0);
    check_eq("rd_valid_in_acq_clear", bad_rdv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
